// File: rtl/uart_pkg.sv
// Shared UART framing constants and FSM state encodings
// for the AXI-Stream to UART bridge.
package uart_pkg;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Single 8N1 byte receiver: synchroniser, start detect,
// mid-bit sampling and stop-bit check.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       busy,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    rx_state_e       state;
    rx_state_e       state_next;
    logic            sync1;
    logic            sync2;
    logic            prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            tick_half;
    logic            tick;
    logic            fall;

    assign tick_half = (cnt == HALF_END);
    assign tick      = (cnt == BIT_END);
    assign fall      = prev & ~sync2;
    assign busy      = (state != RX_IDLE);

    always_comb begin
        state_next = state;
        unique case (state)
            RX_IDLE:  if (fall) state_next = RX_START;
            RX_START: if (tick_half)
                state_next = (sync2 == UART_START_BIT) ? RX_DATA : RX_IDLE;
            RX_DATA:  if (tick && bit_idx == LAST_BIT) state_next = RX_STOP;
            RX_STOP:  if (tick)
                state_next = (sync2 == UART_STOP_BIT) ? RX_IDLE : RX_WAIT;
            RX_WAIT:  if (sync2) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            prev       <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx;
            sync2      <= sync1;
            prev       <= sync2;
            state      <= state_next;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;

            // Timer restarts at the start-bit mid-point so later samples land mid-bit
            if (state == RX_IDLE || state == RX_WAIT)
                cnt <= '0;
            else if (state == RX_START && tick_half)
                cnt <= '0;
            else if (tick)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (state == RX_START && tick_half)
                bit_idx <= '0;

            if (state == RX_DATA && tick) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (state == RX_STOP && tick) begin
                if (sync2 == UART_STOP_BIT) begin
                    byte_valid <= 1'b1;
                    byte_data  <= shreg;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_uart_bridge.sv
// Full-duplex AXI-Stream <-> 8N1 UART bridge with word assembly,
// overrun and inter-byte timeout handling.
module axis_uart_bridge
    import uart_pkg::*;
#(
    parameter int DATA_BYTES      = 8,
    parameter int CLKS_PER_BIT    = 868,
    parameter int MSB_FIRST       = 1,
    parameter int RX_TIMEOUT_BITS = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic                    RsRx,
    output logic                    RsTx,
    output logic                    rx_frame_err,
    output logic                    rx_overrun,
    output logic                    rx_timeout
);

    localparam int W   = 8 * DATA_BYTES;
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int BW  = clog2_min1(DATA_BYTES);
    localparam int TMO = RX_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW  = $clog2(TMO + 1);
    localparam bit MSB = (MSB_FIRST != 0);

    localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TMO_END   = TW'(TMO - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_e     tx_state;
    tx_state_e     tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [BW-1:0] tx_byte;
    logic [W-1:0]  tx_word;
    logic          tx_line;
    logic          tx_tick;
    logic [7:0]    cur_byte;

    assign s_axis_tready = (tx_state == TX_IDLE);
    assign RsTx          = tx_line;
    assign tx_tick       = (tx_cnt == BIT_END);
    assign cur_byte      = MSB ? tx_word[W-1 -: 8] : tx_word[7:0];

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:  if (s_axis_tvalid) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == LAST_BIT) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick)
                tx_next = (tx_byte == LAST_BYTE) ? TX_IDLE : TX_START;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_word  <= '0;
            tx_line  <= UART_STOP_BIT;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
            unique case (tx_state)
                TX_IDLE: if (s_axis_tvalid) begin
                    tx_word <= s_axis_tdata;
                    tx_byte <= '0;
                    tx_line <= UART_START_BIT;
                end
                TX_START: if (tx_tick) begin
                    tx_line <= cur_byte[0];
                    tx_bit  <= '0;
                end
                TX_DATA: if (tx_tick) begin
                    if (tx_bit == LAST_BIT) begin
                        tx_line <= UART_STOP_BIT;
                    end else begin
                        tx_line <= cur_byte[tx_bit + 3'd1];
                        tx_bit  <= tx_bit + 3'd1;
                    end
                end
                TX_STOP: if (tx_tick) begin
                    if (tx_byte == LAST_BYTE) begin
                        tx_line <= UART_STOP_BIT;
                    end else begin
                        tx_line <= UART_START_BIT;
                        tx_byte <= tx_byte + 1'b1;
                        tx_word <= MSB ? (tx_word << 8) : (tx_word >> 8);
                    end
                end
                default: ;
            endcase
        end
    end

    logic          rx_busy;
    logic          rx_bvalid;
    logic [7:0]    rx_byte;
    logic          rx_ferr;
    logic [W-1:0]  rx_word;
    logic [W-1:0]  rx_asm;
    logic [W-1:0]  byte_ext;
    logic [BW-1:0] rx_count;
    logic [TW-1:0] tmo_cnt;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (RsRx),
        .busy      (rx_busy),
        .byte_valid(rx_bvalid),
        .byte_data (rx_byte),
        .frame_err (rx_ferr)
    );

    assign rx_frame_err = rx_ferr;

    always_comb begin
        byte_ext = W'(rx_byte);
        if (MSB)
            rx_asm = (rx_word << 8) | byte_ext;
        else
            rx_asm = (rx_word >> 8) | (byte_ext << (W - 8));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_timeout    <= 1'b0;
            rx_word       <= '0;
            rx_count      <= '0;
            tmo_cnt       <= '0;
        end else begin
            rx_overrun <= 1'b0;
            rx_timeout <= 1'b0;
            if (m_axis_tvalid && m_axis_tready)
                m_axis_tvalid <= 1'b0;

            if (rx_ferr) begin
                rx_count <= '0;
                rx_word  <= '0;
                tmo_cnt  <= '0;
            end else if (rx_bvalid) begin
                tmo_cnt <= '0;
                if (rx_count == LAST_BYTE) begin
                    rx_count <= '0;
                    rx_word  <= '0;
                    // A held word is never overwritten; the new one is dropped
                    if (!m_axis_tvalid) begin
                        m_axis_tdata  <= rx_asm;
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        rx_overrun <= 1'b1;
                    end
                end else begin
                    rx_word  <= rx_asm;
                    rx_count <= rx_count + 1'b1;
                end
            end else if (rx_busy || rx_count == '0) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_END) begin
                tmo_cnt    <= '0;
                rx_count   <= '0;
                rx_word    <= '0;
                rx_timeout <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_uart_bridge.sv
// Directed plus randomized bench for axis_uart_bridge, using
// a word-level reference model and a wire-level frame decoder.
module tb_axis_uart_bridge;

    localparam int C = 16;
    localparam int N = 8;
    localparam int LIM = 5000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] s_tdata_a, s_tdata_b, m_tdata_a, m_tdata_b;
    logic        s_tvalid_a, s_tvalid_b, s_tready_a, s_tready_b;
    logic        m_tvalid_a, m_tvalid_b, m_tready_a, m_tready_b;
    logic        rx_a, tx_a, rx_b, tx_b;
    logic        ferr_a, ovr_a, tmo_a, ferr_b, ovr_b, tmo_b;
    logic        loop_a = 1'b1;
    logic        tb_rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int ferr_n = 0, ovr_n = 0, tmo_n = 0, low_n = 0;

    always #5 clk = ~clk;

    assign rx_a = loop_a ? tx_a : tb_rx;
    assign rx_b = tx_b;

    axis_uart_bridge #(
        .DATA_BYTES(N), .CLKS_PER_BIT(C), .MSB_FIRST(1), .RX_TIMEOUT_BITS(20)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata_a), .s_axis_tvalid(s_tvalid_a),
        .s_axis_tready(s_tready_a),
        .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a),
        .m_axis_tready(m_tready_a),
        .RsRx(rx_a), .RsTx(tx_a),
        .rx_frame_err(ferr_a), .rx_overrun(ovr_a), .rx_timeout(tmo_a)
    );

    axis_uart_bridge #(
        .DATA_BYTES(N), .CLKS_PER_BIT(C), .MSB_FIRST(0), .RX_TIMEOUT_BITS(20)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata_b), .s_axis_tvalid(s_tvalid_b),
        .s_axis_tready(s_tready_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b),
        .m_axis_tready(m_tready_b),
        .RsRx(rx_b), .RsTx(tx_b),
        .rx_frame_err(ferr_b), .rx_overrun(ovr_b), .rx_timeout(tmo_b)
    );

    always @(negedge clk) begin
        if (ferr_a) ferr_n <= ferr_n + 1;
        if (ovr_a) ovr_n <= ovr_n + 1;
        if (tmo_a) tmo_n <= tmo_n + 1;
        if (!s_tready_a) low_n <= low_n + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte i on the wire, straight from the byte-order rule
    function automatic logic [7:0] wire_of(input logic [63:0] w, input int i,
                                           input bit msb);
        int k;
        k = msb ? (N - 1 - i) : i;
        return w[8*k +: 8];
    endfunction

    function automatic logic txpin(input int which);
        return which != 0 ? tx_b : tx_a;
    endfunction

    function automatic logic tready(input int which);
        return which != 0 ? s_tready_b : s_tready_a;
    endfunction

    function automatic logic mvalid(input int which);
        return which != 0 ? m_tvalid_b : m_tvalid_a;
    endfunction

    task automatic send(input int which, input logic [63:0] w);
        int n = 0;
        @(negedge clk);
        if (which != 0) begin
            s_tdata_b = w; s_tvalid_b = 1'b1;
        end else begin
            s_tdata_a = w; s_tvalid_a = 1'b1;
        end
        while (tready(which) !== 1'b1 && n < LIM) begin
            @(negedge clk); n++;
        end
        check("send_ready", tready(which), 1);
        @(posedge clk);
        #1;
        s_tvalid_a = 1'b0;
        s_tvalid_b = 1'b0;
    endtask

    task automatic recv(input int which, output logic [63:0] d);
        int n = 0;
        while (mvalid(which) !== 1'b1 && n < LIM) begin
            @(negedge clk); n++;
        end
        check("recv_valid", mvalid(which), 1);
        d = which != 0 ? m_tdata_b : m_tdata_a;
        if (which != 0) m_tready_b = 1'b1; else m_tready_a = 1'b1;
        @(negedge clk);
        m_tready_a = 1'b0;
        m_tready_b = 1'b0;
    endtask

    task automatic wire_byte(input int which, output logic [7:0] b,
                             output logic ok);
        int n = 0;
        ok = 1'b0;
        b = '0;
        while (txpin(which) !== 1'b0 && n < LIM) begin
            @(negedge clk); n++;
        end
        if (n >= LIM) return;
        repeat (C / 2) @(negedge clk);
        if (txpin(which) !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            b[i] = txpin(which);
        end
        repeat (C) @(negedge clk);
        ok = (txpin(which) === 1'b1);
    endtask

    task automatic ser_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        tb_rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tb_rx = b[i];
            repeat (C) @(negedge clk);
        end
        tb_rx = stop;
        repeat (C) @(negedge clk);
        tb_rx = 1'b1;
    endtask

    task automatic wait_tready(input int which);
        int n = 0;
        while (tready(which) !== 1'b1 && n < LIM) begin
            @(negedge clk); n++;
        end
    endtask

    initial begin
        logic [63:0] w, d;
        logic [7:0]  b;
        logic        ok;
        int          base, base2;
        logic [63:0] q[$];

        s_tdata_a = '0; s_tdata_b = '0;
        s_tvalid_a = 1'b0; s_tvalid_b = 1'b0;
        m_tready_a = 1'b0; m_tready_b = 1'b0;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_tready", s_tready_a, 1);
        check("rst_mvalid", m_tvalid_a, 0);
        check("rst_mdata", m_tdata_a, 0);
        check("rst_pulses", {ferr_a, ovr_a, tmo_a}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // MSB-first loopback
        w = 64'hfeedfacedeadbeef;
        base = low_n;
        send(0, w);
        for (int i = 0; i < N; i++) begin
            wire_byte(0, b, ok);
            check("msb_wire_ok", ok, 1);
            check(i == 0 ? "msb_first_byte" : "msb_wire_byte", b,
                  wire_of(w, i, 1));
        end
        wait_tready(0);
        check("tready_low_cycles", low_n - base, 1280);
        recv(0, d);
        check("msb_rx_word", d, w);

        // LSB-first loopback
        send(1, w);
        for (int i = 0; i < N; i++) begin
            wire_byte(1, b, ok);
            check("lsb_wire_ok", ok, 1);
            check(i == 0 ? "lsb_first_byte" : "lsb_wire_byte", b,
                  wire_of(w, i, 0));
        end
        recv(1, d);
        check("lsb_rx_word", d, w);

        // Framing error on byte 3
        loop_a = 1'b0;
        base = ferr_n;
        base2 = tmo_n;
        w = 64'ha5c3_5a3c_9669_0ff0;
        for (int i = 0; i < 4; i++) ser_byte(wire_of(w, i, 1), i != 3);
        repeat (4 * C) @(negedge clk);
        check("ferr_count", ferr_n - base, 1);
        check("ferr_no_valid", m_tvalid_a, 0);
        w = 64'h0123456789abcdef;
        for (int i = 0; i < N; i++) ser_byte(wire_of(w, i, 1), 1'b1);
        recv(0, d);
        check("ferr_clean_word", d, w);
        check("ferr_no_timeout", tmo_n - base2, 0);

        // Overrun with consumer stalled
        loop_a = 1'b1;
        base = ovr_n;
        send(0, {8{8'h11}});
        send(0, {8{8'h22}});
        wait_tready(0);
        repeat (2 * C) @(negedge clk);
        check("ovr_count", ovr_n - base, 1);
        check("ovr_held_valid", m_tvalid_a, 1);
        check("ovr_held_data", m_tdata_a, {8{8'h11}});
        recv(0, d);
        check("ovr_recv", d, {8{8'h11}});

        // Inter-byte timeout
        loop_a = 1'b0;
        base = tmo_n;
        w = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) ser_byte(wire_of(w, i, 1), 1'b1);
        repeat (25 * C) @(negedge clk);
        check("tmo_count", tmo_n - base, 1);
        check("tmo_no_valid", m_tvalid_a, 0);
        loop_a = 1'b1;
        w = {$urandom, $urandom};
        send(0, w);
        recv(0, d);
        check("tmo_next_word", d, w);

        // Short glitch must not start a byte
        loop_a = 1'b0;
        base = ferr_n;
        base2 = tmo_n;
        @(negedge clk);
        tb_rx = 1'b0;
        repeat (4) @(negedge clk);
        tb_rx = 1'b1;
        repeat (30 * C) @(negedge clk);
        check("glitch_no_valid", m_tvalid_a, 0);
        check("glitch_no_ferr", ferr_n - base, 0);
        check("glitch_no_tmo", tmo_n - base2, 0);
        loop_a = 1'b1;

        // Random words through the loopback
        for (int k = 0; k < 5; k++) begin
            w = {$urandom, $urandom};
            q.push_back(w);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            send(0, w);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            recv(0, d);
            check("rand_word", d, q.pop_front());
        end

        // Asynchronous reset in the middle of a transmission
        send(0, {$urandom, $urandom});
        repeat (300) @(negedge clk);
        base = 0;
        while (tx_a !== 1'b0 && base < LIM) begin
            @(negedge clk); base++;
        end
        check("pre_reset_tx_low", tx_a, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx_a, 1);
        check("async_rst_tready", s_tready_a, 1);
        check("async_rst_mvalid", m_tvalid_a, 0);
        check("async_rst_mdata", m_tdata_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
